// File: rtl/axi4l_lsu_master.sv
// AXI4-Lite initiator that turns an LSU-style req/gnt/rvalid data port into single
// outstanding AXI4-Lite read or write transactions; package and bus interface live here too.

package axi4l_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;
endpackage

interface axi4l_if (
    input logic aclk,
    input logic aresetn
);
    import axi4l_pkg::*;

    addr_t       awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    data_t       wdata;
    strb_t       wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    addr_t       araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    data_t       rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        input  aclk, aresetn, awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready
    );

    modport slave (
        input  aclk, aresetn, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

module axi4l_lsu_master
    import axi4l_pkg::*;
#(
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    axi4l_if.master     axi
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_RESP
    } state_t;

    state_t state_q, state_d;
    addr_t  addr_q, addr_d;
    strb_t  be_q, be_d;
    data_t  wdata_q, wdata_d;
    data_t  rdata_q, rdata_d;
    logic   awvalid_q, awvalid_d;
    logic   wvalid_q, wvalid_d;
    logic   arvalid_q, arvalid_d;
    logic   bready_q, bready_d;
    logic   rready_q, rready_d;
    logic   rvalid_q, rvalid_d;
    logic   err_q, err_d;

    // NOTE: every output of this block is assigned a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        rvalid_d  = 1'b0;
        err_d     = err_q;
        gnt_o     = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
                    addr_d  = addr_i;
                    be_d    = be_i;
                    wdata_d = wdata_i;
                    if (we_i) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end

            WR_ADDR_DATA: begin
                // AW and W retire independently; move on once neither is still pending.
                if (awvalid_q && axi.awready) awvalid_d = 1'b0;
                if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end

            WR_RESP: begin
                if (axi.bvalid && bready_q) begin
                    bready_d = 1'b0;
                    rvalid_d = 1'b1;
                    err_d    = (axi.bresp != RESP_OKAY);
                    state_d  = IDLE;
                end
            end

            RD_ADDR: begin
                if (arvalid_q && axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end

            RD_RESP: begin
                if (axi.rvalid && rready_q) begin
                    rready_d = 1'b0;
                    rvalid_d = 1'b1;
                    rdata_d  = axi.rdata;
                    err_d    = (axi.rresp != RESP_OKAY);
                    state_d  = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: the latched request fields are reset as well, so the bus never shows X after reset.
    always_ff @(posedge axi.aclk or negedge axi.aresetn) begin
        if (!axi.aresetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

    assign axi.awaddr  = addr_q;
    assign axi.awprot  = PROT;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = be_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = PROT;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule
